// File: rtl/seq_div_pkg.sv
// Shared types and cell functions for the sequential restoring array divider.
package seq_div_pkg;

   // Default divisor width and the matching row-counter width.
   localparam int DIV_D_W_DEFAULT = 8;
   localparam int DIV_CNT_W       = $clog2(DIV_D_W_DEFAULT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Exact full-subtractor cell: difference bit.
   function automatic logic cell_exact_diff(input logic x, input logic y, input logic bin);
      return x ^ y ^ bin;
   endfunction

   // Exact full-subtractor cell: borrow out.
   function automatic logic cell_exact_bout(input logic x, input logic y, input logic bin);
      return (~x & y) | (~(x ^ y) & bin);
   endfunction

   // Approximate cell: difference bit from a single NAND-style term.
   function automatic logic cell_approx_diff(input logic x, input logic y, input logic bin);
      return ~(x & ~y & ~bin);
   endfunction

   // Approximate cell: borrow is tied high, so the row never reports "fits".
   function automatic logic cell_approx_bout();
      return 1'b1;
   endfunction

endpackage

// File: rtl/div_row.sv
// One combinational subtractor row of the restoring divider: evaluates x - d
// through a D_W-cell borrow chain and restores x when the divisor does not fit.
module div_row
   import seq_div_pkg::*;
#(
   parameter int D_W = DIV_D_W_DEFAULT
)(
   input  logic           t,
   input  logic [D_W-1:0] x,
   input  logic [D_W-1:0] d,
   input  logic           approx,
   output logic           q_bit,
   output logic [D_W-1:0] rem_new
);

   logic [D_W-1:0] diff;
   logic [D_W:0]   borrow;

   // Ripple the borrow from the LSB cell upward using exact or approximate cells.
   always_comb begin
      diff   = '0;
      borrow = '0;
      for (int i = 0; i < D_W; i++) begin
         if (approx) begin
            diff[i]     = cell_approx_diff(x[i], d[i], borrow[i]);
            borrow[i+1] = cell_approx_bout();
         end else begin
            diff[i]     = cell_exact_diff(x[i], d[i], borrow[i]);
            borrow[i+1] = cell_exact_bout(x[i], d[i], borrow[i]);
         end
      end
   end

   // A set window top bit means the partial remainder already exceeds d.
   assign q_bit   = t | ~borrow[D_W];
   assign rem_new = q_bit ? diff : x;

endmodule

// File: rtl/seq_array_divider.sv
// Iterative restoring array divider: one subtractor row per clock, MSB row first.
// Optional feature macro: DIV_APPROX_EN compiles in approximate low-order rows
// (rows k < APPROX_ROWS) that the per-request exact bit can override.
module seq_array_divider
   import seq_div_pkg::*;
#(
   parameter int D_W         = DIV_D_W_DEFAULT,
   parameter int APPROX_ROWS = 6
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*D_W-1:0] n,
   input  logic [D_W-1:0]   d,
   input  logic             exact,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [D_W-1:0]   q,
   output logic [D_W-1:0]   r,
   output logic             ovf,
   output logic             div0
);

   // Counter width follows the package value for the default width.
   localparam int             K_W   = (D_W == DIV_D_W_DEFAULT) ? DIV_CNT_W : $clog2(D_W);
   localparam logic [K_W-1:0] K_MAX = K_W'(D_W - 1);

   div_state_e       state_r, state_nxt;
   logic [K_W-1:0]   k_r;
   logic             t_r;
   logic [D_W-1:0]   x_r;
   logic [D_W-1:0]   d_r;
   logic [D_W-2:0]   n_sh_r;
   logic [D_W-2:0]   q_acc_r;
   logic             row_approx;
   logic             row_q;
   logic [D_W-1:0]   row_rem;
   logic             accept;
   logic             busy;

   assign accept = in_valid & in_ready;
   assign busy   = (state_r == BUSY);

`ifdef DIV_APPROX_EN
   localparam logic [K_W:0] APPROX_LIM = (K_W+1)'(APPROX_ROWS);
   logic exact_r;

   // Capture the per-request exact override with the operands.
   always_ff @(posedge clk) begin
      if (accept) exact_r <= exact;
   end

   assign row_approx = ({1'b0, k_r} < APPROX_LIM) & ~exact_r;
`else
   logic unused_exact;
   assign unused_exact = exact ^ (APPROX_ROWS > 0);
   assign row_approx   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_nxt;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_nxt = state_r;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            if (k_r == '0) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   div_row #(.D_W(D_W)) u_row (
      .t       (t_r),
      .x       (x_r),
      .d       (d_r),
      .approx  (row_approx),
      .q_bit   (row_q),
      .rem_new (row_rem)
   );

   // Working window: load on acceptance, then shift one dividend bit in per row.
   always_ff @(posedge clk) begin
      if (accept) begin
         d_r    <= d;
         t_r    <= n[2*D_W-1];
         x_r    <= n[2*D_W-2:D_W-1];
         n_sh_r <= n[D_W-2:0];
      end else if (busy) begin
         t_r     <= row_rem[D_W-1];
         x_r     <= {row_rem[D_W-2:0], n_sh_r[D_W-2]};
         n_sh_r  <= n_sh_r << 1;
         q_acc_r <= (q_acc_r << 1) | (D_W-1)'(row_q);
      end
   end

   // Row counter, status flags and the registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         k_r  <= K_MAX;
         q    <= '0;
         r    <= '0;
         ovf  <= 1'b0;
         div0 <= 1'b0;
      end else if (accept) begin
         k_r  <= K_MAX;
         ovf  <= (n[2*D_W-1:D_W] >= d) && (d != '0);
         div0 <= (d == '0);
      end else if (busy) begin
         if (k_r == '0) begin
            k_r <= K_MAX;
            q   <= {q_acc_r, row_q};
            r   <= row_rem;
         end else begin
            k_r <= k_r - K_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seq_array_divider.sv
// Self-checking bench for seq_array_divider (D_W=8, APPROX_ROWS=6).
module tb_seq_array_divider;

`ifdef DIV_APPROX_EN
   localparam bit APX = 1'b1;
`else
   localparam bit APX = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] n;
   logic [7:0]  d;
   logic        exact;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  q;
   logic [7:0]  r;
   logic        ovf;
   logic        div0;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] n;
      logic [7:0]  d;
      bit          ex;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        ovf;
      logic        div0;
   } vec_t;

   vec_t vecs[7];

   seq_array_divider #(.D_W(8), .APPROX_ROWS(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .n         (n),
      .d         (d),
      .exact     (exact),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .r         (r),
      .ovf       (ovf),
      .div0      (div0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: no response within cycle budget", name);
   endtask

   // Row-by-row restoring division from the cell rules, using integer compare/subtract.
   function automatic void model(input logic [15:0] nn, input logic [7:0] dd, input bit ex,
                                 output logic [7:0] qm, output logic [7:0] rm);
      logic       t;
      logic [7:0] x, nw, diff;
      bit         qb;
      t  = nn[15];
      x  = nn[14:7];
      qm = '0;
      rm = '0;
      for (int k = 7; k >= 0; k--) begin
         if (APX && (k < 6) && !ex) begin
            qb   = t;
            diff = {7'h7F, ~(x[0] & ~dd[0])};
         end else begin
            qb   = t || (x >= dd);
            diff = x - dd;
         end
         nw    = qb ? diff : x;
         qm[k] = qb;
         if (k > 0) begin
            t = nw[7];
            x = {nw[6:0], nn[k-1]};
         end else begin
            rm = nw;
         end
      end
   endfunction

   // One full transaction starting from IDLE; lat counts edges from acceptance to out_valid.
   task automatic run_op(input logic [15:0] nn, input logic [7:0] dd, input bit ex,
                         output logic [7:0] qq, output logic [7:0] rr,
                         output logic ov, output logic dz, output int lat);
      @(negedge clk);
      n = nn; d = dd; exact = ex; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) timeout_fail("op_timeout");
      qq = q; rr = r; ov = ovf; dz = div0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  qq, rr, qe, re;
      logic        ov, dz, ove, dze;
      logic [15:0] nn;
      logic [7:0]  dd;
      bit          ex;
      int          lat, cyc, seen;
      int          acc[$];

      vecs[0] = '{16'd1000,  8'd7,    1'b1, 8'd142,                8'd6,                  1'b0, 1'b0};
      vecs[1] = '{16'd1000,  8'd7,    1'b0, APX ? 8'd128 : 8'd142, APX ? 8'd104 : 8'd6,   1'b0, 1'b0};
      vecs[2] = '{16'd1000,  8'd7,    1'b1, 8'd142,                8'd6,                  1'b0, 1'b0};
      vecs[3] = '{16'h1234,  8'h56,   1'b1, 8'd54,                 8'd16,                 1'b0, 1'b0};
      vecs[4] = '{16'h0900,  8'd8,    1'b1, 8'hFF,                 8'h08,                 1'b1, 1'b0};
      vecs[5] = '{16'h00AB,  8'd0,    1'b1, 8'hFF,                 8'hAB,                 1'b0, 1'b1};
      vecs[6] = '{16'd0,     8'd1,    1'b1, 8'd0,                  8'd0,                  1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; n = '0; d = '0; exact = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_q", q, 0);
      chk("rst_r", r, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_div0", div0, 0);

      // Directed vectors
      foreach (vecs[i]) begin
         run_op(vecs[i].n, vecs[i].d, vecs[i].ex, qq, rr, ov, dz, lat);
         chk($sformatf("vec%0d_q", i), qq, vecs[i].q);
         chk($sformatf("vec%0d_r", i), rr, vecs[i].r);
         chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
         chk($sformatf("vec%0d_div0", i), dz, vecs[i].div0);
         chk($sformatf("vec%0d_latency", i), lat, 8);
      end

      // Stall in DONE with out_ready low; request pulsed during BUSY must be ignored
      @(negedge clk);
      n = 16'd1000; d = 8'd7; exact = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
      n = 16'h1234; d = 8'h56; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      if (!out_valid) timeout_fail("stall_timeout");
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall%0d_q", i), q, 142);
         chk($sformatf("stall%0d_r", i), r, 6);
         chk($sformatf("stall%0d_in_ready", i), in_ready, 0);
         chk($sformatf("stall%0d_out_valid", i), out_valid, 1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_in_ready", in_ready, 1);
      chk("release_out_valid", out_valid, 0);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("ignored_request", seen, 0);

      // Reset while row 4 is pending
      @(negedge clk);
      n = 16'h1234; d = 8'h56; exact = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_q", q, 0);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_result", seen, 0);
      run_op(16'd0, 8'd1, 1'b1, qq, rr, ov, dz, lat);
      chk("post_abort_q", qq, 0);
      chk("post_abort_r", rr, 0);
      chk("post_abort_ovf", ov, 0);

      // Back-to-back throughput with out_ready held high
      @(negedge clk);
      n = 16'd1000; d = 8'd7; exact = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      cyc = 0;
      while (acc.size() < 3 && cyc < 80) begin
         if (in_ready) acc.push_back(cyc);
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      if (acc.size() < 3) begin
         timeout_fail("throughput_timeout");
      end else begin
         chk("throughput_gap1", acc[1] - acc[0], 10);
         chk("throughput_gap2", acc[2] - acc[1], 10);
      end
      repeat (15) @(negedge clk);
      out_ready = 1'b0;

      // Randomized operations against the reference model
      for (int i = 0; i < 150; i++) begin
         ex = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            dd = 8'($urandom_range(1, 255));
            nn = {8'($urandom_range(0, int'(dd) - 1)), 8'($urandom_range(0, 255))};
         end else begin
            dd = 8'($urandom_range(0, 255));
            nn = 16'($urandom_range(0, 65535));
         end
         ove = (nn[15:8] >= dd) && (dd != 0);
         dze = (dd == 0);
         if (!(APX && !ex) && dd != 0 && !ove) begin
            qe = 8'(nn / dd);
            re = 8'(nn % dd);
         end else begin
            model(nn, dd, ex, qe, re);
         end
         run_op(nn, dd, ex, qq, rr, ov, dz, lat);
         chk($sformatf("rand%0d_q n=%0h d=%0h ex=%0d", i, nn, dd, ex), qq, qe);
         chk($sformatf("rand%0d_r n=%0h d=%0h ex=%0d", i, nn, dd, ex), rr, re);
         chk($sformatf("rand%0d_ovf", i), ov, ove);
         chk($sformatf("rand%0d_div0", i), dz, dze);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_array_divider.md
# seq_array_divider

Parametrised, iterative restoring array divider that computes one D_W-bit unsigned quotient and remainder from a 2·D_W-bit dividend. It evaluates one subtractor row per clock, MSB row first, instead of the fully combinational array. A configurable number of low-order rows use the approximate subtractor cell; a per-request `exact` bit overrides them at run time. It sits between the operand-issue logic and the result consumer in the approximate-arithmetic datapath, with valid/ready on both sides.

## Interface
- `D_W`, 8, divisor/quotient/remainder width; dividend is 2·D_W.
- `APPROX_ROWS`, 6, number of rows k < APPROX_ROWS that use approximate cells (0..D_W).
- `clk`  in  1  clock; the block uses one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `n`  in  2·D_W  dividend.
- `d`  in  D_W  divisor.
- `exact`  in  1  when 1, all rows use exact cells for this operation.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `q`  out  D_W  quotient.
- `r`  out  D_W  remainder.
- `ovf`  out  1  `n[2D_W-1:D_W] >= d` with `d != 0`; the quotient is truncated.
- `div0`  out  1  `d == 0`.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - BUSY: row counter k runs from D_W-1 down to 0.
  - DONE: `out_valid=1`.
- IDLE→BUSY on `in_valid&in_ready`. On that edge, latch d, n, `exact`, `ovf` and `div0`. Initialise window top t=n[2D_W-1] and x=n[2D_W-2:D_W-1].
- Each BUSY cycle evaluates row k, a D_W-cell borrow chain computing x − d with borrow-in 0:
  - Exact cell: diff = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
  - Approximate cell (row k < APPROX_ROWS and latched exact=0): diff = ~(x&~y&~bin); bout = 1.
  - q[k] = t | ~bout_msb.
  - new = q[k] ? diff : x.
- Next row: t = new[D_W-1]; x = {new[D_W-2:0], n[k-1]}.
- After row 0, r = new. BUSY→DONE.
- DONE→IDLE on `out_ready`. q, r, `ovf` and `div0` hold stable while `out_valid=1`.
- `d==0` in exact mode: the array yields q = all-ones and r = n[D_W-1:0]. No special-case logic is added; `div0` flags it.
- `in_valid` while not IDLE is ignored and not captured.
- Overflow: the array result is returned unmodified and `ovf` is set.

## Timing
- Reset (synchronous): state=IDLE, k=D_W-1, `in_ready=1`, `out_valid=0`, q=0, r=0, `ovf=0`, `div0=0`.
- Reset asserted mid-BUSY or in DONE aborts the operation. No result is produced, and the block is back in IDLE the cycle after reset deasserts.
- Latency: if acceptance is at edge E, `out_valid` rises after edge E+D_W.
- Back-to-back throughput: D_W+2 cycles per operation when `out_ready` is held high.
- `in_ready` drops the cycle after acceptance. It reasserts the cycle after the `out_valid&out_ready` edge.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `DIV_APPROX_EN` defined: approximate cells and the `exact` port behaviour are compiled in as above.
- `DIV_APPROX_EN` not defined: every row is exact, `APPROX_ROWS` is ignored, and `exact` is accepted but unused. Results equal true restoring division.

## Structure
- Package `seq_div_pkg` holds:
  - the state enum {IDLE, BUSY, DONE};
  - exact and approximate cell functions (diff and bout);
  - the localparam for the counter width, $clog2(D_W).
- Sub-module `div_row`: one combinational D_W-cell row with inputs t, x, d and `approx`, and outputs q_bit and new. The top level instantiates one `div_row` and reuses it each cycle.

## Test plan
- Exact, n=1000, d=7 → q=142, r=6, `ovf=0`, `div0=0`; `out_valid` rises 8 cycles after acceptance.
- Approximate (`exact=0`, APPROX_ROWS=6), n=1000, d=7 → q=128, r=104. Same operands with `exact=1` → q=142, r=6.
- Exact, n=0x1234, d=0x56 → q=54, r=16. Then n=0x0900, d=8 → `ovf=1`.
- n=0x00AB, d=0, exact → q=0xFF, r=0xAB, `div0=1`.
- Hold `out_ready=0` for 5 cycles in DONE → q and r stable, `in_ready=0`. Pulse `in_valid` during BUSY with new operands → ignored.
- Assert `rst` at BUSY row 4 → next cycle `out_valid=0`, `in_ready=1`. A fresh n=0, d=1 → q=0, r=0.
